// File: rtl/sdr_data_path_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sdr_dp_pkg
// Shared constants and helpers for the SDR SDRAM data path.
//   - DSIZE_DEFAULT : data bus width used when no override is given
//   - legal ranges for WR_DLY, CAS_LAT, RD_EXTRA and BURST_LEN
//   - cnt_width()   : width of the read burst counter
// -----------------------------------------------------------------------------
package sdr_dp_pkg;

    localparam int DSIZE_DEFAULT = 32;

    localparam int WR_DLY_MIN   = 1;
    localparam int WR_DLY_MAX   = 4;
    localparam int CAS_LAT_MIN  = 2;
    localparam int CAS_LAT_MAX  = 3;
    localparam int RD_EXTRA_MAX = 2;

    // Burst counter must be able to hold BURST_LEN itself.
    function automatic int cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

    function automatic bit burst_len_legal(input int burst_len);
        return (burst_len == 1) || (burst_len == 2) ||
               (burst_len == 4) || (burst_len == 8);
    endfunction

endpackage

// File: rtl/sdr_data_path_pipe_if.sv
// -----------------------------------------------------------------------------
// sdr_data_path_pipe_if
// Bundles the host/pad side signals of the SDR data path.
//   master : environment side (control path, host, SDRAM DQ input)
//   slave  : the data path itself
// Signals:
//   OE, DATAIN, DM   write request, data and byte masks from the host
//   RD_CMD           one-cycle pulse issued with the READ command
//   DQIN             SDRAM DQ input
//   DQOUT, DQ_OE, DQM  delayed write data, pad enable and data masks
//   DATAOUT, DATAOUT_VALID, RD_LAST  captured read words to the host
// -----------------------------------------------------------------------------
interface sdr_data_path_pipe_if
    import sdr_dp_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEFAULT
);
    logic                 OE;
    logic [DSIZE-1:0]     DATAIN;
    logic [DSIZE/8-1:0]   DM;
    logic                 RD_CMD;
    logic [DSIZE-1:0]     DQIN;
    logic [DSIZE-1:0]     DQOUT;
    logic                 DQ_OE;
    logic [DSIZE/8-1:0]   DQM;
    logic [DSIZE-1:0]     DATAOUT;
    logic                 DATAOUT_VALID;
    logic                 RD_LAST;

    modport master (
        output OE, DATAIN, DM, RD_CMD, DQIN,
        input  DQOUT, DQ_OE, DQM, DATAOUT, DATAOUT_VALID, RD_LAST
    );

    modport slave (
        input  OE, DATAIN, DM, RD_CMD, DQIN,
        output DQOUT, DQ_OE, DQM, DATAOUT, DATAOUT_VALID, RD_LAST
    );
endinterface

// File: rtl/sdr_data_path_pipe_delay_line.sv
// -----------------------------------------------------------------------------
// sdr_delay_line
// Plain shift register of DEPTH stages, each WIDTH bits, cleared to zero by
// the asynchronous reset. dout presents din delayed by DEPTH rising edges.
//   CLK    clock
//   RESET  asynchronous active-high reset
//   din    data into stage 0
//   dout   output of the last stage
// -----------------------------------------------------------------------------
module sdr_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge CLK or posedge RESET) begin
                    if (RESET) q_reg <= '0;
                    else       q_reg <= din;
                end
            end else begin : g_tail
                always_ff @(posedge CLK or posedge RESET) begin
                    if (RESET) q_reg <= '0;
                    else       q_reg <= g_stage[gi-1].q_reg;
                end
            end
        end
    endgenerate

    assign dout = g_stage[DEPTH-1].q_reg;
endmodule

// File: rtl/sdr_data_path_pipe.sv
// -----------------------------------------------------------------------------
// sdr_data_path_pipe
// Parametrised SDR SDRAM data path between the control path and the pads.
//   Write path: {OE, DM, DATAIN} delayed WR_DLY edges onto DQ_OE/DQM/DQOUT.
//               DQM is held at zero while a read word is being captured and
//               the pads are not driving, so reads are never masked.
//   Read path : RD_CMD travels a token line of CAS_LAT+RD_EXTRA stages; when
//               it emerges, BURST_LEN consecutive DQIN words are captured
//               into DATAOUT with DATAOUT_VALID, RD_LAST on the final word.
//               A token emerging mid-burst restarts the burst (read
//               interrupt): the old burst ends without RD_LAST.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-high reset
//   bus    sdr_data_path_pipe_if.slave (host, pad and read-return signals)
// -----------------------------------------------------------------------------
module sdr_data_path_pipe
    import sdr_dp_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEFAULT,
    parameter int WR_DLY    = 2,
    parameter int CAS_LAT   = 2,
    parameter int RD_EXTRA  = 0,
    parameter int BURST_LEN = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    sdr_data_path_pipe_if.slave  bus
);
    localparam int NB = DSIZE / 8;
    localparam int WW = 1 + NB + DSIZE;
    localparam int RL = CAS_LAT + RD_EXTRA;
    localparam int CW = cnt_width(BURST_LEN);
    localparam logic [CW-1:0] BL_M1 = CW'(BURST_LEN - 1);

    // ---------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ---------------------------------------------------------------------
    generate
        if ((DSIZE < 8) || (DSIZE % 8 != 0)) begin : g_bad_dsize
            $error("sdr_data_path_pipe: DSIZE=%0d must be a multiple of 8", DSIZE);
        end
        if ((WR_DLY < WR_DLY_MIN) || (WR_DLY > WR_DLY_MAX)) begin : g_bad_wr_dly
            $error("sdr_data_path_pipe: WR_DLY=%0d out of range", WR_DLY);
        end
        if ((CAS_LAT < CAS_LAT_MIN) || (CAS_LAT > CAS_LAT_MAX)) begin : g_bad_cas
            $error("sdr_data_path_pipe: CAS_LAT=%0d out of range", CAS_LAT);
        end
        if ((RD_EXTRA < 0) || (RD_EXTRA > RD_EXTRA_MAX)) begin : g_bad_extra
            $error("sdr_data_path_pipe: RD_EXTRA=%0d out of range", RD_EXTRA);
        end
        if (!burst_len_legal(BURST_LEN)) begin : g_bad_bl
            $error("sdr_data_path_pipe: BURST_LEN=%0d not 1/2/4/8", BURST_LEN);
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Write path
    // ---------------------------------------------------------------------
    logic [WW-1:0]    wr_in;
    logic [WW-1:0]    wr_out;
    logic             dq_oe_dly;
    logic [NB-1:0]    dm_dly;
    logic [DSIZE-1:0] dq_dly;

    assign wr_in = {bus.OE, bus.DM, bus.DATAIN};

    sdr_delay_line #(
        .WIDTH (WW),
        .DEPTH (WR_DLY)
    ) u_wr_dly (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (wr_in),
        .dout  (wr_out)
    );

    assign dq_oe_dly = wr_out[WW-1];
    assign dm_dly    = wr_out[DSIZE +: NB];
    assign dq_dly    = wr_out[DSIZE-1:0];

    // ---------------------------------------------------------------------
    // Read token line
    // ---------------------------------------------------------------------
    logic tok_emerge;

    sdr_delay_line #(
        .WIDTH (1),
        .DEPTH (RL)
    ) u_rd_tok (
        .CLK   (CLK),
        .RESET (RESET),
        .din   (bus.RD_CMD),
        .dout  (tok_emerge)
    );

    // ---------------------------------------------------------------------
    // Capture
    // The edge that consumes the emerging token already captures the first
    // word, so cnt_reg holds the number of words still due after the one
    // just taken. A word is sampled on the next edge whenever the token is
    // at the end of the line or cnt_reg is nonzero.
    // ---------------------------------------------------------------------
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [DSIZE-1:0] dataout_reg, dataout_next;
    logic             valid_reg, valid_next;
    logic             last_reg, last_next;
    logic             capture_active;

    assign capture_active = tok_emerge | (cnt_reg != '0);

    always_comb begin
        cnt_next     = cnt_reg;
        dataout_next = dataout_reg;
        valid_next   = 1'b0;
        last_next    = 1'b0;
        if (tok_emerge) begin
            // New or interrupting burst: restart the count, the truncated
            // burst never reaches its last word.
            cnt_next     = BL_M1;
            dataout_next = bus.DQIN;
            valid_next   = 1'b1;
            last_next    = (BURST_LEN == 1);
        end else if (cnt_reg != '0) begin
            cnt_next     = cnt_reg - CW'(1);
            dataout_next = bus.DQIN;
            valid_next   = 1'b1;
            last_next    = (cnt_reg == CW'(1));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_reg     <= '0;
            dataout_reg <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            dataout_reg <= dataout_next;
            valid_reg   <= valid_next;
            last_reg    <= last_next;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.DQOUT         = dq_dly;
    assign bus.DQ_OE         = dq_oe_dly;
    assign bus.DQM           = (capture_active && !dq_oe_dly) ? '0 : dm_dly;
    assign bus.DATAOUT       = dataout_reg;
    assign bus.DATAOUT_VALID = valid_reg;
    assign bus.RD_LAST       = last_reg;

endmodule

// File: tb/tb_sdr_data_path_pipe.sv
// -----------------------------------------------------------------------------
// tb_sdr_data_path_pipe
// Two data path instances share clock, reset and write stimulus:
//   dut 0 : defaults (WR_DLY 2, CAS 2, EXTRA 0, BL 4)
//   dut 1 : WR_DLY 3, CAS 3, EXTRA 1, BL 8
// Expected write and read results are queued when stimulus is driven and
// compared on the falling edge after the edge at which they are due.
// -----------------------------------------------------------------------------
module tb_sdr_data_path_pipe;
    import sdr_dp_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        last;
    } rd_exp_t;

    typedef struct {
        int          cyc;
        logic        oe;
        logic [3:0]  dm;
        logic [31:0] data;
    } wr_exp_t;

    typedef struct {
        logic        oe;
        logic [31:0] datain;
        logic [3:0]  dm;
        logic        rd;
        logic        exp_oe;
        logic [31:0] exp_dq;
        logic [3:0]  exp_dm;
    } wr_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        oe = 1'b0;
    logic [31:0] datain = '0;
    logic [3:0]  dm = '0;
    logic [31:0] dqin = '0;
    logic        rd_a = 1'b0;
    logic        rd_b = 1'b0;

    always #5 clk = ~clk;

    sdr_data_path_pipe_if #(.DSIZE(32)) bus_a ();
    sdr_data_path_pipe_if #(.DSIZE(32)) bus_b ();

    assign bus_a.OE = oe;  assign bus_a.DATAIN = datain;  assign bus_a.DM = dm;
    assign bus_a.DQIN = dqin;  assign bus_a.RD_CMD = rd_a;
    assign bus_b.OE = oe;  assign bus_b.DATAIN = datain;  assign bus_b.DM = dm;
    assign bus_b.DQIN = dqin;  assign bus_b.RD_CMD = rd_b;

    sdr_data_path_pipe #(
        .DSIZE(32), .WR_DLY(2), .CAS_LAT(2), .RD_EXTRA(0), .BURST_LEN(4)
    ) u_dut_a (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_a)
    );

    sdr_data_path_pipe #(
        .DSIZE(32), .WR_DLY(3), .CAS_LAT(3), .RD_EXTRA(1), .BURST_LEN(8)
    ) u_dut_b (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus_b)
    );

    logic [31:0] o_dqout [2];
    logic        o_dq_oe [2];
    logic [3:0]  o_dqm   [2];
    logic [31:0] o_dout  [2];
    logic        o_valid [2];
    logic        o_last  [2];

    assign o_dqout[0] = bus_a.DQOUT;   assign o_dqout[1] = bus_b.DQOUT;
    assign o_dq_oe[0] = bus_a.DQ_OE;   assign o_dq_oe[1] = bus_b.DQ_OE;
    assign o_dqm[0]   = bus_a.DQM;     assign o_dqm[1]   = bus_b.DQM;
    assign o_dout[0]  = bus_a.DATAOUT; assign o_dout[1]  = bus_b.DATAOUT;
    assign o_valid[0] = bus_a.DATAOUT_VALID; assign o_valid[1] = bus_b.DATAOUT_VALID;
    assign o_last[0]  = bus_a.RD_LAST; assign o_last[1]  = bus_b.RD_LAST;

    // Model configuration per instance
    int wr_dly_m [2] = '{2, 3};
    int rl_m     [2] = '{2, 4};
    int bl_m     [2] = '{4, 8};

    rd_exp_t     rdq [2][$];
    wr_exp_t     wrq [2][$];
    logic [31:0] held [2] = '{32'h0, 32'h0};

    int      cyc = 0;
    int      n_vec = 0;
    int      n_bad = 0;
    bit      use_tbl = 1'b0;
    wr_vec_t pend;

    // DQIN value presented for edge e; distinct every cycle.
    function automatic logic [31:0] pat(input int e);
        return 32'(e - 6);
    endfunction

    task automatic push_read(input int d, input int e);
        int first;
        first = e + rl_m[d];
        // A newer token truncates whatever is still due from an older burst.
        while (rdq[d].size() > 0 && rdq[d][$].cyc >= first)
            void'(rdq[d].pop_back());
        for (int k = 0; k < bl_m[d]; k++)
            rdq[d].push_back('{first + k, pat(first + k), (k == bl_m[d] - 1)});
    endtask

    task automatic flush_model();
        for (int d = 0; d < 2; d++) begin
            rdq[d].delete();
            wrq[d].delete();
            held[d] = '0;
        end
    endtask

    task automatic check(input int d);
        logic        exp_v, exp_l, exp_oe, cap, bad;
        logic [31:0] exp_dq;
        logic [3:0]  exp_dm;
        wr_exp_t     w;
        exp_v = 1'b0; exp_l = 1'b0; exp_oe = 1'b0; cap = 1'b0; bad = 1'b0;
        exp_dq = '0; exp_dm = '0;
        if (rst) begin
            held[d] = '0;
        end else begin
            if (rdq[d].size() > 0 && rdq[d][0].cyc == cyc) begin
                exp_v   = 1'b1;
                exp_l   = rdq[d][0].last;
                held[d] = rdq[d][0].data;
                void'(rdq[d].pop_front());
            end
            cap = (rdq[d].size() > 0 && rdq[d][0].cyc == cyc + 1);
            if (wrq[d].size() > 0 && wrq[d][0].cyc == cyc) begin
                w      = wrq[d].pop_front();
                exp_oe = w.oe;
                exp_dq = w.data;
                exp_dm = w.dm;
            end
            if (cap && !exp_oe) exp_dm = '0;
        end
        n_vec++;
        if (o_valid[d] !== exp_v) begin
            $display("FAIL dut%0d cyc%0d VALID got %0b want %0b", d, cyc, o_valid[d], exp_v);
            bad = 1'b1;
        end
        if (o_last[d] !== exp_l) begin
            $display("FAIL dut%0d cyc%0d RD_LAST got %0b want %0b", d, cyc, o_last[d], exp_l);
            bad = 1'b1;
        end
        if (o_dout[d] !== held[d]) begin
            $display("FAIL dut%0d cyc%0d DATAOUT got %h want %h", d, cyc, o_dout[d], held[d]);
            bad = 1'b1;
        end
        if (o_dq_oe[d] !== exp_oe) begin
            $display("FAIL dut%0d cyc%0d DQ_OE got %0b want %0b", d, cyc, o_dq_oe[d], exp_oe);
            bad = 1'b1;
        end
        if (o_dqout[d] !== exp_dq) begin
            $display("FAIL dut%0d cyc%0d DQOUT got %h want %h", d, cyc, o_dqout[d], exp_dq);
            bad = 1'b1;
        end
        if (o_dqm[d] !== exp_dm) begin
            $display("FAIL dut%0d cyc%0d DQM got %h want %h", d, cyc, o_dqm[d], exp_dm);
            bad = 1'b1;
        end
        if (bad) n_bad++;
        $display("dut%0d cyc%0d rst=%0b valid=%0b last=%0b dout=%h dq_oe=%0b dqout=%h dqm=%h",
                 d, cyc, rst, o_valid[d], o_last[d], o_dout[d], o_dq_oe[d], o_dqout[d], o_dqm[d]);
    endtask

    // Inputs are already set (on a falling edge); queue what they should
    // produce, take one rising edge, then compare on the falling edge.
    task automatic tick();
        int e;
        e    = cyc + 1;
        dqin = pat(e);
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (use_tbl)
                    wrq[d].push_back('{e + wr_dly_m[d] - 1, pend.exp_oe, pend.exp_dm, pend.exp_dq});
                else
                    wrq[d].push_back('{e + wr_dly_m[d] - 1, oe, dm, datain});
            end
            if (rd_a) push_read(0, e);
            if (rd_b) push_read(1, e);
        end
        @(posedge clk);
        cyc = e;
        @(negedge clk);
        check(0);
        check(1);
    endtask

    task automatic run_to(input int n);
        while (cyc < n - 1) tick();
    endtask

    wr_vec_t tbl [8];

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        //            oe    datain         dm      rd    exp_oe exp_dq         exp_dm
        tbl[0] = '{1'b1, 32'hA5A5_0001, 4'b0010, 1'b0, 1'b1, 32'hA5A5_0001, 4'b0010};
        tbl[1] = '{1'b0, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 32'h0000_0000, 4'b0000};
        tbl[2] = '{1'b1, 32'h1234_5678, 4'b1001, 1'b1, 1'b1, 32'h1234_5678, 4'b1001};
        tbl[3] = '{1'b0, 32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b1111};
        tbl[4] = '{1'b1, 32'h0F0F_0F0F, 4'b0101, 1'b0, 1'b1, 32'h0F0F_0F0F, 4'b0101};
        tbl[5] = '{1'b0, 32'hDEAD_BEEF, 4'b1010, 1'b0, 1'b0, 32'hDEAD_BEEF, 4'b1010};
        tbl[6] = '{1'b0, 32'hCAFE_F00D, 4'b0110, 1'b0, 1'b0, 32'hCAFE_F00D, 4'b0110};
        tbl[7] = '{1'b1, 32'h8000_0001, 4'b1111, 1'b0, 1'b1, 32'h8000_0001, 4'b1111};

        // Reset state
        repeat (3) tick();
        rst = 1'b0;

        // Write vectors from edge 10; one carries a simultaneous read on dut 0
        run_to(10);
        for (int i = 0; i < 8; i++) begin
            oe = tbl[i].oe; datain = tbl[i].datain; dm = tbl[i].dm; rd_a = tbl[i].rd;
            pend = tbl[i]; use_tbl = 1'b1;
            tick();
            use_tbl = 1'b0;
        end
        oe = 1'b0; datain = '0; dm = '0; rd_a = 1'b0;

        // Single burst on dut 0 at edge 20
        run_to(20); rd_a = 1'b1; tick(); rd_a = 1'b0;

        // Two BL=8 bursts on dut 1 spaced exactly BURST_LEN apart
        run_to(30); rd_b = 1'b1; tick(); rd_b = 1'b0;
        run_to(38); rd_b = 1'b1; tick(); rd_b = 1'b0;

        // Read interrupt on dut 0
        run_to(40); rd_a = 1'b1; tick(); rd_a = 1'b0;
        run_to(42); rd_a = 1'b1; tick(); rd_a = 1'b0;

        // Masks held high with pads off across two contiguous bursts
        run_to(48); dm = 4'hF;
        run_to(50); rd_a = 1'b1; tick(); rd_a = 1'b0;
        run_to(54); rd_a = 1'b1; tick(); rd_a = 1'b0;
        run_to(62); dm = 4'h0;

        // Reset pulse while the second word of a burst is on DATAOUT
        run_to(70); rd_a = 1'b1; tick(); rd_a = 1'b0;
        run_to(74);
        rst = 1'b1;
        flush_model();
        #1;
        check(0);
        check(1);
        tick();
        rst = 1'b0;

        // Quiet after reset, then a fresh read on both instances
        run_to(85); rd_a = 1'b1; rd_b = 1'b1; tick(); rd_a = 1'b0; rd_b = 1'b0;
        run_to(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
